// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for a 16x16 LED dot matrix with per-row blanking
// and frame-granular horizontal scrolling.
module dot_matrix_scanner #(
    parameter int CLK_DIV         = 1000,
    parameter int BLANK           = 2,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        scroll_en,
    output logic [3:0]  row_bin,
    input  logic [15:0] col_in,
    output logic [15:0] row_sel,
    output logic [15:0] col_out,
    output logic        frame_tick,
    output logic [3:0]  shift
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [TW-1:0] ROW_LAST   = TW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]    row_bin_q, row_bin_d;
    logic [15:0]   row_sel_q, row_sel_d;
    logic [15:0]   col_out_q, col_out_d;
    logic          frame_tick_q, frame_tick_d;
    logic [3:0]    shift_q, shift_d;

    function automatic logic [15:0] rotl16(input logic [15:0] x,
                                           input logic [3:0]  s);
        logic [31:0] d;
        d = {x, x} << s;
        return d[31:16];
    endfunction

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        row_bin_d    = row_bin_q;
        row_sel_d    = row_sel_q;
        col_out_d    = col_out_q;
        frame_tick_d = 1'b0;
        shift_d      = shift_q;

        if (!en) begin
            // Dropping enable darkens the panel but keeps row/scroll position
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            row_sel_d  = '0;
            col_out_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = '0;
                    row_sel_d  = '0;
                    col_out_d  = '0;
                    state_d    = ST_BLANK;
                end
                ST_BLANK: begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                    if (tick_cnt_q == BLANK_LAST) begin
                        row_sel_d = 16'h0001 << row_bin_q;
                        col_out_d = rotl16(col_in, shift_q);
                        state_d   = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (tick_cnt_q == ROW_LAST) begin
                        tick_cnt_d = '0;
                        row_sel_d  = '0;
                        col_out_d  = '0;
                        row_bin_d  = row_bin_q + 4'd1;
                        state_d    = ST_BLANK;
                        if (row_bin_q == 4'hF) begin
                            frame_tick_d = 1'b1;
                            if (scroll_en) begin
                                if (frame_cnt_q == FRAME_LAST) begin
                                    frame_cnt_d = '0;
                                    shift_d     = shift_q + 4'd1;
                                end else begin
                                    frame_cnt_d = frame_cnt_q + FW'(1);
                                end
                            end
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            row_bin_q    <= '0;
            row_sel_q    <= '0;
            col_out_q    <= '0;
            frame_tick_q <= 1'b0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            row_bin_q    <= row_bin_d;
            row_sel_q    <= row_sel_d;
            col_out_q    <= col_out_d;
            frame_tick_q <= frame_tick_d;
            shift_q      <= shift_d;
        end
    end

    assign row_bin    = row_bin_q;
    assign row_sel    = row_sel_q;
    assign col_out    = col_out_q;
    assign frame_tick = frame_tick_q;
    assign shift      = shift_q;

endmodule
